// File: rtl/pwallace_mac.sv
// pwallace_mac: pipelined Wallace-tree multiply-accumulate.
// Stage 0 registers the operands. Partial products (modified Baugh-Wooley
// when sgn=1) are reduced by a tree of 3:2 compressors into a redundant
// sum/carry pair that is registered at stage 1. The carry-propagate add is
// placed in the next register stage, or is merged into the final stage when
// STAGES=2. The final stage extends the product and loads it or adds it to
// the accumulator. An operation sampled at edge N is reported in the cycle
// after edge N+STAGES.
module pwallace_mac #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter int GUARD  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     sgn,
  input  logic                     acc,
  output logic                     out_valid,
  output logic [2*WIDTH+GUARD-1:0] out,
  output logic                     ovf
);

  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = PW + GUARD;
  localparam int NR    = WIDTH + 1;  // WIDTH partial-product rows plus the Baugh-Wooley constant row

  // Row count entering reduction level lvl. Each level turns every group of
  // three rows into two and passes the leftover rows through unchanged.
  function automatic int rows_at(input int n0, input int lvl);
    int n;
    n = n0;
    for (int i = 0; i < lvl; i++) n = n - n / 3;
    return n;
  endfunction

  // Number of 3:2 levels needed to get down to two rows.
  function automatic int num_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = n - n / 3;
      l = l + 1;
    end
    return l;
  endfunction

  localparam int LVLS = num_levels(NR);

  // Modified Baugh-Wooley constant: 2^WIDTH + 2^(2*WIDTH-1), modulo 2^(2*WIDTH).
  localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  // Stage 0: registered operands.
  logic             v0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             sgn0;
  logic             acc0;

  // Stage 1: redundant sum/carry pair from the tree.
  logic             v1;
  logic [PW-1:0]    sum1;
  logic [PW-1:0]    car1;
  logic             sgn1;
  logic             acc1;

  // Operand fields seen by the final accumulate stage.
  logic             fin_v;
  logic [PW-1:0]    fin_p;
  logic             fin_sgn;
  logic             fin_acc;

  logic [ACC_W-1:0] acc_reg;

  // Valid bits of stages 0 and 1; reset drops any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      v0 <= in_valid;
      v1 <= v0;
    end
  end

  // Stage 0 data capture; data registers carry no reset, only valid does.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      a0   <= a;
      b0   <= b;
      sgn0 <= sgn;
      acc0 <= acc;
    end
  end

  // ------------------------------------------------------------------
  // Partial-product generation
  // ------------------------------------------------------------------
  logic [PW-1:0] pp [NR];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      // In signed mode the terms that involve exactly one operand sign bit
      // are inverted; the sign-times-sign term stays positive.
      localparam logic [WIDTH-1:0] INV = (gi == WIDTH - 1) ?
                                         {1'b0, {(WIDTH-1){1'b1}}} :
                                         {1'b1, {(WIDTH-1){1'b0}}};
      logic [WIDTH-1:0] bits;
      assign bits   = (a0 & {WIDTH{b0[gi]}}) ^ (INV & {WIDTH{sgn0}});
      assign pp[gi] = {{WIDTH{1'b0}}, bits} << gi;
    end
  endgenerate

  assign pp[WIDTH] = sgn0 ? BW_CORR : '0;

  // ------------------------------------------------------------------
  // Wallace reduction: each level is a column of 3:2 compressors.
  // Carries beyond bit PW-1 are dropped since the product is mod 2^PW.
  // ------------------------------------------------------------------
  genvar gl, gg, gr;
  generate
    for (gl = 0; gl < LVLS; gl++) begin : g_lvl
      localparam int N = rows_at(NR, gl);
      localparam int G = N / 3;
      logic [PW-1:0] src [N];
      logic [PW-1:0] dst [N-G];

      if (gl == 0) begin : g_from_pp
        assign src = pp;
      end else begin : g_from_prev
        assign src = g_lvl[gl-1].dst;
      end

      for (gg = 0; gg < G; gg++) begin : g_csa
        assign dst[2*gg]   = src[3*gg] ^ src[3*gg+1] ^ src[3*gg+2];
        assign dst[2*gg+1] = ((src[3*gg]   & src[3*gg+1]) |
                              (src[3*gg]   & src[3*gg+2]) |
                              (src[3*gg+1] & src[3*gg+2])) << 1;
      end

      for (gr = 3 * G; gr < N; gr++) begin : g_pass
        assign dst[gr-G] = src[gr];
      end
    end
  endgenerate

  logic [PW-1:0] tree_s;
  logic [PW-1:0] tree_c;
  assign tree_s = g_lvl[LVLS-1].dst[0];
  assign tree_c = g_lvl[LVLS-1].dst[1];

  // Stage 1 data: register the redundant pair and the per-operation mode bits.
  always_ff @(posedge clk) begin
    if (v0) begin
      sum1 <= tree_s;
      car1 <= tree_c;
      sgn1 <= sgn0;
      acc1 <= acc0;
    end
  end

  // ------------------------------------------------------------------
  // Carry-propagate add and delay stages
  // ------------------------------------------------------------------
  generate
    if (STAGES == 2) begin : g_short
      // No room for a separate CPA stage: the add feeds the accumulator directly.
      assign fin_v   = v1;
      assign fin_p   = sum1 + car1;
      assign fin_sgn = sgn1;
      assign fin_acc = acc1;
    end else begin : g_mid
      localparam int D = STAGES - 2;
      logic [D-1:0]  dv;
      logic [D-1:0]  ds;
      logic [D-1:0]  da;
      logic [PW-1:0] dp [D];

      // Valid shift chain through the CPA/delay stages.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dv <= '0;
        end else begin
          dv <= D'({dv, v1});
        end
      end

      // First delay stage resolves the carry; later ones just move the product.
      always_ff @(posedge clk) begin
        if (v1) begin
          dp[0] <= sum1 + car1;
          ds[0] <= sgn1;
          da[0] <= acc1;
        end
        for (int i = 1; i < D; i++) begin
          if (dv[i-1]) begin
            dp[i] <= dp[i-1];
            ds[i] <= ds[i-1];
            da[i] <= da[i-1];
          end
        end
      end

      assign fin_v   = dv[D-1];
      assign fin_p   = dp[D-1];
      assign fin_sgn = ds[D-1];
      assign fin_acc = da[D-1];
    end
  endgenerate

  // ------------------------------------------------------------------
  // Final stage: extend, load or accumulate, overflow detect
  // ------------------------------------------------------------------
  logic [ACC_W-1:0] ext;
  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] result;
  logic             ovf_hit;

  // Extension, accumulate sum and overflow condition for the operation at the last stage.
  always_comb begin
    ext     = fin_sgn ? {{GUARD{fin_p[PW-1]}}, fin_p} : {{GUARD{1'b0}}, fin_p};
    sum_w   = {1'b0, acc_reg} + {1'b0, ext};
    result  = fin_acc ? sum_w[ACC_W-1:0] : ext;
    ovf_hit = 1'b0;
    if (fin_sgn) begin
      // Two same-sign addends producing a result of the other sign.
      ovf_hit = (acc_reg[ACC_W-1] == ext[ACC_W-1]) &&
                (sum_w[ACC_W-1] != acc_reg[ACC_W-1]);
    end else begin
      ovf_hit = sum_w[ACC_W];
    end
  end

  // Output/accumulator register: updates only on a valid operation; ovf is sticky across accumulates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      acc_reg   <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= fin_v;
      if (fin_v) begin
        acc_reg <= result;
        ovf     <= fin_acc ? (ovf | ovf_hit) : 1'b0;
      end
    end
  end

  assign out = acc_reg;

endmodule

// File: tb/tb_pwallace_mac.sv
// Table-driven bench for pwallace_mac (WIDTH=8, STAGES=3, GUARD=4).
module tb_pwallace_mac;

  localparam int WIDTH  = 8;
  localparam int STAGES = 3;
  localparam int GUARD  = 4;
  localparam int ACC_W  = 2 * WIDTH + GUARD;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sgn;
  logic             acc;
  logic             out_valid;
  logic [ACC_W-1:0] out;
  logic             ovf;

  pwallace_mac #(.WIDTH(WIDTH), .STAGES(STAGES), .GUARD(GUARD)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .sgn      (sgn),
    .acc      (acc),
    .out_valid(out_valid),
    .out      (out),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sgn;
    logic             acc;
    logic [ACC_W-1:0] eout;
    logic             eovf;
  } vec_t;

  vec_t             tbl[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [ACC_W-1:0] last_out;
  logic             last_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void add(input int v, input int aa, input int bb, input int s,
                              input int ac, input int eo, input int eov);
    vec_t t;
    t.v    = (v != 0);
    t.a    = WIDTH'(aa);
    t.b    = WIDTH'(bb);
    t.sgn  = (s != 0);
    t.acc  = (ac != 0);
    t.eout = ACC_W'(eo);
    t.eovf = (eov != 0);
    tbl.push_back(t);
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    sgn      = 1'($urandom);
    acc      = 1'($urandom);
  endtask

  // Issue the table back to back (bubbles where v=0), checking every cycle.
  task automatic run_table(input string sect);
    int n;
    int idx;
    n = tbl.size();
    for (int e = 0; e < n + STAGES; e++) begin
      if (e < n && tbl[e].v) begin
        in_valid = 1'b1;
        a        = tbl[e].a;
        b        = tbl[e].b;
        sgn      = tbl[e].sgn;
        acc      = tbl[e].acc;
      end else begin
        drive_idle();
      end
      @(posedge clk);
      #1;
      idx = e - STAGES;
      if (idx >= 0 && tbl[idx].v) begin
        chk($sformatf("%s[%0d] out_valid", sect, idx), 32'(out_valid), 32'd1);
        chk($sformatf("%s[%0d] out", sect, idx), 32'(out), 32'(tbl[idx].eout));
        chk($sformatf("%s[%0d] ovf", sect, idx), 32'(ovf), 32'(tbl[idx].eovf));
        last_out = tbl[idx].eout;
        last_ovf = tbl[idx].eovf;
        $display("txn %s[%0d] a=0x%02h b=0x%02h sgn=%0d acc=%0d -> out=%0d ovf=%0d",
                 sect, idx, tbl[idx].a, tbl[idx].b, tbl[idx].sgn, tbl[idx].acc, out, ovf);
      end else begin
        chk($sformatf("%s cyc%0d idle out_valid", sect, e), 32'(out_valid), 32'd0);
        chk($sformatf("%s cyc%0d hold out", sect, e), 32'(out), 32'(last_out));
        chk($sformatf("%s cyc%0d hold ovf", sect, e), 32'(ovf), 32'(last_ovf));
      end
    end
    tbl.delete();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    last_out = '0;
    last_ovf = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out", 32'(out), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    reset = 1'b0;

    // Basic unsigned, first op right after reset release
    add(1, 3, 55, 0, 0, 165, 0);
    run_table("basic");

    // Signed/unsigned modes, switched per operation
    add(1, 'hF7, 'hBC, 1, 0, 612, 0);
    add(1, 'hF7, 'hBC, 0, 0, 46436, 0);
    add(1, 'h80, 'h80, 1, 0, 16384, 0);
    add(1, 'hFF, 'hFF, 0, 0, 65025, 0);
    add(1, 'h7F, 'h80, 1, 0, 'hFC080, 0);
    add(1, 'hFF, 'h01, 1, 0, 'hFFFFF, 0);
    run_table("mode");

    // Streaming at full rate
    add(1, 7, 63, 0, 0, 441, 0);
    add(1, 119, 106, 0, 0, 12614, 0);
    add(1, 103, 63, 0, 0, 6489, 0);
    run_table("stream");

    // Streaming with one bubble
    add(1, 7, 63, 0, 0, 441, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 119, 106, 0, 0, 12614, 0);
    add(1, 103, 63, 0, 0, 6489, 0);
    run_table("bubble");

    // Unsigned accumulate to carry-out, sticky ovf, then a load clears it
    add(1, 255, 255, 0, 0, 65025, 0);
    for (int k = 2; k <= 17; k++) begin
      if (k == 6) add(0, 0, 0, 0, 0, 0, 0);
      add(1, 255, 255, 0, 1, (k * 65025) % 1048576, (k == 17) ? 1 : 0);
    end
    add(1, 1, 1, 0, 1, 56850, 1);
    add(1, 2, 3, 0, 0, 6, 0);
    run_table("uacc");

    // Signed accumulate
    add(1, 'h80, 'h7F, 1, 0, 'hFC080, 0);
    add(1, 'hFF, 'hFF, 1, 1, 'hFC081, 0);
    run_table("sacc");

    // Signed accumulate up to two's-complement overflow at 2^19
    add(1, 'h80, 'h80, 1, 0, 16384, 0);
    for (int k = 2; k <= 32; k++) begin
      add(1, 'h80, 'h80, 1, 1, (k * 16384) % 1048576, (k == 32) ? 1 : 0);
    end
    run_table("sovf");

    // Reset with two operations in flight
    in_valid = 1'b1; a = 8'd9; b = 8'd9; sgn = 1'b0; acc = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; a = 8'd4; b = 8'd4; sgn = 1'b0; acc = 1'b1;
    @(posedge clk);
    #1;
    drive_idle();
    reset = 1'b1;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset out", 32'(out), 32'd0);
    chk("async reset ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_out = '0;
    last_ovf = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("flushed cyc%0d out_valid", c), 32'(out_valid), 32'd0);
      chk($sformatf("flushed cyc%0d out", c), 32'(out), 32'd0);
      chk($sformatf("flushed cyc%0d ovf", c), 32'(ovf), 32'd0);
    end
    add(1, 5, 5, 0, 1, 25, 0);
    run_table("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwallace_mac.md
PWALLACE_MAC -- requirements
Module: pwallace_mac

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 4..32.
REQ-002 The block SHALL have parameter STAGES, default 3, giving the pipeline latency in cycles; legal range is 2..6.
REQ-003 The block SHALL have parameter GUARD, default 4, giving the accumulator guard bits; ACC_W = 2*WIDTH+GUARD.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a, b, sgn and acc are sampled this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits: the multiplicand.
REQ-008 The block SHALL have port b, input, WIDTH bits: the multiplier.
REQ-009 The block SHALL have port sgn, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-010 The block SHALL have port acc, input, 1 bit: 1 = add the product to the running accumulator, 0 = load the product.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out and ovf are valid this cycle.
REQ-012 The block SHALL have port out, output, ACC_W bits: the result.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky accumulate-overflow flag.

Function
REQ-014 The block SHALL form the product as a Wallace tree: partial-product generation (Baugh-Wooley when sgn=1), CSA reduction levels, and a final carry-propagate adder, with register boundaries distributed over STAGES stages.
REQ-015 The block SHALL accept one operation per cycle with no stall and no backpressure; there is no ready signal.
REQ-016 The latency SHALL be exactly STAGES: an operation sampled at rising edge N produces out_valid=1 for exactly the cycle after edge N+STAGES.
REQ-017 The sgn and acc bits SHALL travel down the pipeline with their operands, so mode changes between consecutive operations take effect per operation.
REQ-018 The product width SHALL be 2*WIDTH; it is sign-extended to ACC_W when sgn=1 and zero-extended when sgn=0.
REQ-019 The final stage, on a valid operation, SHALL compute result = acc ? (acc_reg + ext_prod) mod 2^ACC_W : ext_prod, then drive out = result and set acc_reg = result.
REQ-020 When acc=0, ovf SHALL be cleared to 0 on that operation's output.
REQ-021 When acc=1, ovf SHALL be set to 1 if the addition overflows: signed overflow of ACC_W when sgn=1, carry out of bit ACC_W-1 when sgn=0. Otherwise ovf holds its value (sticky).
REQ-022 In cycles with out_valid=0, out, ovf and acc_reg SHALL hold their last values.
REQ-023 An acc=1 operation issued while the accumulator is still at its reset value (0) SHALL behave as a load.
REQ-024 A bubble (in_valid=0) SHALL propagate as out_valid=0 after STAGES cycles and SHALL NOT disturb acc_reg.
REQ-025 Back-to-back dependent accumulate operations SHALL be correct at full throughput, because accumulation happens only in the final stage.
REQ-026 The sgn=1 case a = b = -2^(WIDTH-1) SHALL produce +2^(2*WIDTH-2) correctly.

Reset
REQ-027 Assertion of reset SHALL immediately and asynchronously clear all pipeline valid bits, out_valid, out, ovf and acc_reg to 0, including during an operation in flight.
REQ-028 Data registers that carry no valid SHALL NOT be required to be reset.
REQ-029 In-flight operations SHALL be discarded by reset and never appear at the output.
REQ-030 The first operation sampled on the first rising edge after deassertion SHALL follow REQ-016.

Verification (WIDTH=8, STAGES=3, GUARD=4, ACC_W=20)
REQ-031 Basic unsigned: a=3, b=55, sgn=0, acc=0 -> out_valid after 3 cycles, out=165, ovf=0.
REQ-032 Mode: a=0xF7, b=0xBC with sgn=1 -> out=612; the same operands with sgn=0 -> out=46436; a=b=0x80 with sgn=1 -> out=16384.
REQ-033 Streaming: (7,63), (119,106), (103,63) on consecutive cycles -> outputs 441, 12614, 6489 on three consecutive cycles. A single bubble inserted in the stream -> a single out_valid=0 gap.
REQ-034 Accumulate and overflow: (255,255) with acc=0, then 16 operations (255,255) with acc=1, sgn=0 -> outputs 65025, 130050, ... The 16th accumulate outputs 56849 with ovf=1; a following acc=0 operation (2,3) -> out=6, ovf=0.
REQ-035 Signed accumulate: (-128,127) with acc=0, then (-1,-1) with acc=1 -> outputs 0xFC080 (-16256) then 0xFC081 (-16255), ovf=0.
REQ-036 Reset mid-flight: assert reset for one cycle while 2 operations are in flight -> out_valid stays 0, out=0, ovf=0. A following acc=1 operation (5,5) -> out=25.
